cc_lives_counter: RTL
=====================

# cc_lives_counter

Holds the player's remaining-lives count for the Frogger game and drives the lives bus consumed by the downstream zero-lives comparator. It accepts collision hits and bonus-life pulses and applies a post-hit invulnerability (guard) window. It also issues a one-cycle respawn pulse and a sticky game-over flag. It sits between the collision/goal logic and the lives comparator and score/display path.

## Interface

Parameters:
- LIVES_COUNTER_DATAWIDTH, 3: width of the lives bus; must match the downstream comparator.
- LIVES_INIT, 3: lives loaded at reset and new game; 1 ≤ LIVES_INIT ≤ LIVES_MAX.
- LIVES_MAX, 7: saturation ceiling for bonus lives; ≤ 2^LIVES_COUNTER_DATAWIDTH − 1.
- GUARD_CYCLES, 50000000: length of the guard window in clock cycles (1 s at 50 MHz); ≥ 1.

Ports:
- CC_LIVES_COUNTER_CLOCK_50  in  1: system clock; single clock domain.
- CC_LIVES_COUNTER_RESET_InLow  in  1: reset, **asynchronous, active-low**.
- CC_LIVES_COUNTER_newGame_In  in  1: synchronous reload to a fresh game; active-high.
- CC_LIVES_COUNTER_hit_In  in  1: collision level, synchronous to the clock. Only rising edges count.
- CC_LIVES_COUNTER_bonus_In  in  1: single-cycle pulse requesting +1 life.
- CC_LIVES_COUNTER_lives_Out  out  LIVES_COUNTER_DATAWIDTH: current lives; feeds the comparator.
- CC_LIVES_COUNTER_guard_Out  out  1: high while the guard window is active.
- CC_LIVES_COUNTER_respawn_Out  out  1: one-cycle pulse when a hit is accepted.
- CC_LIVES_COUNTER_gameOver_Out  out  1: high in OVER state.

## Operation

- FSM states: PLAY, GUARD, OVER.
- Reset (asynchronous) sets the following immediately: state PLAY, lives = LIVES_INIT, guard counter = 0, hit history register = 0, and all flag outputs = 0.
- Hit edge detection: edge = hit_In & ~hit_q, where hit_q is hit_In registered.
- Priority per cycle is reset, then newGame, then hit/bonus.
- newGame, from any state:
  - Sets lives = LIVES_INIT, state PLAY, guard counter 0, and gameOver 0.
  - Does not pulse respawn.
  - Loads hit_q with the current hit_In, so a held hit does not count.
- PLAY, hit edge, lives > 1: lives −1, respawn pulse, load guard counter with GUARD_CYCLES−1, go to GUARD.
- PLAY, hit edge, lives = 1: lives becomes 0, respawn pulse, go to OVER.
- PLAY, hit edge and bonus in the same cycle: lives unchanged, respawn pulse, go to GUARD. Game over is never entered in this case.
- Bonus, without a simultaneous hit, is accepted in PLAY and GUARD: lives +1, saturating at LIVES_MAX.
- GUARD:
  - Hit edges are consumed and discarded, not queued.
  - The guard counter decrements each cycle. The cycle it reads 0, the next state is PLAY.
- OVER:
  - lives held at 0; hit and bonus are ignored.
  - Left only via newGame or reset.
- Lives never wraps: it never goes below 0 and never goes above LIVES_MAX.

## Timing

- All outputs are registered.
- Latency from hit_In first sampled high to lives_Out, respawn_Out and guard_Out updating is 1 clock.
- respawn_Out is high for exactly 1 cycle per accepted hit.
- guard_Out is high for exactly GUARD_CYCLES cycles, then PLAY resumes. A hit edge in the first PLAY cycle after the window is accepted.
- gameOver_Out rises in the same cycle that lives_Out becomes 0.
- Bonus latency is 1 clock.
- newGame takes effect at the next clock edge.
- Reset mid-GUARD or mid-OVER clears outputs immediately, without waiting for a clock.

## Structure

- Shared package/include file holds:
  - State encoding: PLAY = 2'b00, GUARD = 2'b01, OVER = 2'b10.
  - Default lives constants.
- One sub-module, cc_guard_timer:
  - Down-counter of width $clog2(GUARD_CYCLES).
  - Inputs: load, clock, reset.
  - Output: a done flag.
- FSM, edge detector and lives register live in the top level.

## Test plan

Parameters for all scenarios: DATAWIDTH = 3, LIVES_INIT = 3, LIVES_MAX = 5, GUARD_CYCLES = 4.

1. Release reset → lives_Out = 3, guard/respawn/gameOver = 0.
2. Raise hit for 1 cycle → next cycle lives = 2, respawn high for 1 cycle, guard high for 4 cycles. A second hit edge during guard leaves lives = 2.
3. Three hits spaced more than 4 cycles apart → lives goes 2, 1, 0. gameOver = 1 together with lives = 0. Further hits and bonuses leave lives = 0, and the comparator output goes low.
4. Five bonus pulses from 3 → lives = 5 (saturated). At lives = 1, hit and bonus in the same cycle → lives stays 1, guard = 1, gameOver = 0.
5. newGame asserted during GUARD while hit is held high → lives = 3, guard = 0. No decrement until hit falls and rises again.
6. Assert reset asynchronously mid-guard at lives = 1 → outputs are immediately lives = 3 and guard = 0.

Source files
------------

// File: rtl/cc_lives_counter_pkg.sv
// Shared types and defaults for the Frogger lives counter.
// State encoding is fixed so downstream debug taps can decode it directly.
package cc_lives_counter_pkg;

    typedef enum logic [1:0] {
        PLAY  = 2'b00,
        GUARD = 2'b01,
        OVER  = 2'b10
    } livesState_e;

    localparam int unsigned DEFAULT_DATAWIDTH    = 3;
    localparam int unsigned DEFAULT_LIVES_INIT   = 3;
    localparam int unsigned DEFAULT_LIVES_MAX    = 7;
    localparam int unsigned DEFAULT_GUARD_CYCLES = 50000000;

    // Increment that sticks at the ceiling instead of wrapping.
    function automatic int unsigned satInc(input int unsigned value, input int unsigned ceiling);
        return (value < ceiling) ? value + 1 : ceiling;
    endfunction

endpackage

// File: rtl/cc_lives_counter_if.sv
// Lives bus between the collision/goal logic (master) and the lives counter (slave).
interface cc_lives_counter_if #(
    parameter int unsigned LIVES_COUNTER_DATAWIDTH = 3
);
    logic                               CC_LIVES_COUNTER_newGame_In;
    logic                               CC_LIVES_COUNTER_hit_In;
    logic                               CC_LIVES_COUNTER_bonus_In;
    logic [LIVES_COUNTER_DATAWIDTH-1:0] CC_LIVES_COUNTER_lives_Out;
    logic                               CC_LIVES_COUNTER_guard_Out;
    logic                               CC_LIVES_COUNTER_respawn_Out;
    logic                               CC_LIVES_COUNTER_gameOver_Out;

    modport master (
        output CC_LIVES_COUNTER_newGame_In,
        output CC_LIVES_COUNTER_hit_In,
        output CC_LIVES_COUNTER_bonus_In,
        input  CC_LIVES_COUNTER_lives_Out,
        input  CC_LIVES_COUNTER_guard_Out,
        input  CC_LIVES_COUNTER_respawn_Out,
        input  CC_LIVES_COUNTER_gameOver_Out
    );

    modport slave (
        input  CC_LIVES_COUNTER_newGame_In,
        input  CC_LIVES_COUNTER_hit_In,
        input  CC_LIVES_COUNTER_bonus_In,
        output CC_LIVES_COUNTER_lives_Out,
        output CC_LIVES_COUNTER_guard_Out,
        output CC_LIVES_COUNTER_respawn_Out,
        output CC_LIVES_COUNTER_gameOver_Out
    );
endinterface

// File: rtl/cc_guard_timer.sv
// Post-hit invulnerability down-counter; done is high while the count sits at zero.
module cc_guard_timer
    import cc_lives_counter_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES = DEFAULT_GUARD_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    output logic done
);
    // A single-cycle window still needs one storage bit.
    localparam int unsigned TW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [TW-1:0] LOAD_VALUE = TW'(GUARD_CYCLES - 1);

    logic [TW-1:0] countQ;
    logic          doneQ;

    // done is registered alongside the count so it mirrors countQ == 0 without a comparator path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            countQ <= '0;
            doneQ  <= 1'b1;
        end else if (clear) begin
            countQ <= '0;
            doneQ  <= 1'b1;
        end else if (load) begin
            countQ <= LOAD_VALUE;
            doneQ  <= (GUARD_CYCLES == 1);
        end else begin
            if (countQ != '0) begin
                countQ <= countQ - TW'(1);
            end
            doneQ <= (countQ <= TW'(1));
        end
    end

    assign done = doneQ;

endmodule

// File: rtl/cc_lives_counter.sv
// Frogger remaining-lives counter: hit/bonus handling, guard window, respawn pulse, game-over flag.
module cc_lives_counter
    import cc_lives_counter_pkg::*;
#(
    parameter int unsigned LIVES_COUNTER_DATAWIDTH = DEFAULT_DATAWIDTH,
    parameter int unsigned LIVES_INIT              = DEFAULT_LIVES_INIT,
    parameter int unsigned LIVES_MAX               = DEFAULT_LIVES_MAX,
    parameter int unsigned GUARD_CYCLES            = DEFAULT_GUARD_CYCLES
) (
    input  logic               CC_LIVES_COUNTER_CLOCK_50,
    input  logic               CC_LIVES_COUNTER_RESET_InLow,
    cc_lives_counter_if.slave  livesBus
);
    localparam int unsigned LW = LIVES_COUNTER_DATAWIDTH;
    localparam logic [LW-1:0] LIVES_INIT_V = LW'(LIVES_INIT);
    localparam logic [LW-1:0] ONE_V        = LW'(1);

    livesState_e   stateQ, stateNext;
    logic [LW-1:0] livesQ, livesNext;
    logic          hitQ;
    logic          hitEdge;
    logic          respawnNext;
    logic          guardQ, respawnQ, gameOverQ;
    logic          timerLoad, timerClear, timerDone;

    assign hitEdge = livesBus.CC_LIVES_COUNTER_hit_In & ~hitQ;

    cc_guard_timer #(
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_guardTimer (
        .clk   (CC_LIVES_COUNTER_CLOCK_50),
        .rst_n (CC_LIVES_COUNTER_RESET_InLow),
        .load  (timerLoad),
        .clear (timerClear),
        .done  (timerDone)
    );

    // State, lives and flag registers; flags are derived from the next state so they align with lives.
    always_ff @(posedge CC_LIVES_COUNTER_CLOCK_50 or negedge CC_LIVES_COUNTER_RESET_InLow) begin
        if (!CC_LIVES_COUNTER_RESET_InLow) begin
            stateQ    <= PLAY;
            livesQ    <= LIVES_INIT_V;
            hitQ      <= 1'b0;
            guardQ    <= 1'b0;
            respawnQ  <= 1'b0;
            gameOverQ <= 1'b0;
        end else begin
            stateQ    <= stateNext;
            livesQ    <= livesNext;
            hitQ      <= livesBus.CC_LIVES_COUNTER_hit_In;
            guardQ    <= (stateNext == GUARD);
            respawnQ  <= respawnNext;
            gameOverQ <= (stateNext == OVER);
        end
    end

    // Next-state and lives update; newGame overrides everything except reset.
    always_comb begin
        stateNext   = stateQ;
        livesNext   = livesQ;
        respawnNext = 1'b0;
        timerLoad   = 1'b0;
        timerClear  = 1'b0;

        if (livesBus.CC_LIVES_COUNTER_newGame_In) begin
            stateNext  = PLAY;
            livesNext  = LIVES_INIT_V;
            timerClear = 1'b1;
        end else begin
            case (stateQ)
                PLAY: begin
                    if (hitEdge) begin
                        respawnNext = 1'b1;
                        // A bonus in the same cycle cancels the loss but still grants the guard window.
                        if (livesBus.CC_LIVES_COUNTER_bonus_In) begin
                            stateNext = GUARD;
                            timerLoad = 1'b1;
                        end else if (livesQ > ONE_V) begin
                            livesNext = livesQ - ONE_V;
                            stateNext = GUARD;
                            timerLoad = 1'b1;
                        end else begin
                            livesNext = '0;
                            stateNext = OVER;
                        end
                    end else if (livesBus.CC_LIVES_COUNTER_bonus_In) begin
                        livesNext = LW'(satInc(32'(livesQ), LIVES_MAX));
                    end
                end
                GUARD: begin
                    if (livesBus.CC_LIVES_COUNTER_bonus_In && !hitEdge) begin
                        livesNext = LW'(satInc(32'(livesQ), LIVES_MAX));
                    end
                    if (timerDone) begin
                        stateNext = PLAY;
                    end
                end
                OVER: begin
                    livesNext = '0;
                end
                default: begin
                    stateNext = PLAY;
                    livesNext = LIVES_INIT_V;
                end
            endcase
        end
    end

    assign livesBus.CC_LIVES_COUNTER_lives_Out    = livesQ;
    assign livesBus.CC_LIVES_COUNTER_guard_Out    = guardQ;
    assign livesBus.CC_LIVES_COUNTER_respawn_Out  = respawnQ;
    assign livesBus.CC_LIVES_COUNTER_gameOver_Out = gameOverQ;

endmodule
